// File: rtl/axis_mux_pkg.sv
// Shared definitions for the 12-input AXI-Stream bus mux and its schedulers.
// Select-code layout: bit 7 marks a valid selection, low bits carry the FIFO index.
package axis_mux_pkg;

   localparam int         SEL_VALID_BIT = 7;
   localparam logic [7:0] SEL_NONE      = 8'd0;
   localparam int         NUM_FIFO      = 12;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   function automatic logic [7:0] sel_code(input logic [6:0] idx);
      logic [7:0] code;
      code                = {1'b0, idx};
      code[SEL_VALID_BIT] = 1'b1;
      return code;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: returns the first set request bit at or after ptr,
// wrapping from NUM_IN-1 back to 0. ptr is expected to be below NUM_IN.
module rr_pick #(
   parameter int NUM_IN = 12,
   parameter int IDX_W  = 4
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [IDX_W-1:0]  idx,
   output logic              found
);

   localparam int SUM_W = IDX_W + 1;

   logic [NUM_IN-1:0] hit;
   logic [IDX_W-1:0]  cand [NUM_IN];

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
         logic [SUM_W-1:0] sum;
         assign sum      = {1'b0, ptr} + SUM_W'(gi);
         assign cand[gi] = (sum >= SUM_W'(NUM_IN)) ? IDX_W'(sum - SUM_W'(NUM_IN))
                                                   : sum[IDX_W-1:0];
         assign hit[gi]  = req[cand[gi]];
      end
   endgenerate

   // Scan from the far offset down so the nearest hit to ptr is the one that sticks.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (hit[k]) begin
            idx   = cand[k];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin scheduler for the AXI-Stream bus mux: holds each grant
// until a tlast handshake (or the beat watchdog) and steers tready to the granted FIFO.
module axis_pkt_arbiter
   import axis_mux_pkg::*;
#(
   parameter int NUM_IN        = NUM_FIFO,
   parameter int IDX_W         = 4,
   parameter int MAX_PKT_BEATS = 1024,
   parameter int CNT_W         = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arb_en,
   input  logic [NUM_IN-1:0] fifo_pkt_rdy,
   input  logic              mux_tvalid,
   input  logic              mux_tlast,
   input  logic              axis_out_tready,
   output logic [7:0]        bus_sel,
   output logic [NUM_IN-1:0] fifo_tready,
   output logic              busy,
   output logic              pkt_done,
   output logic [IDX_W-1:0]  pkt_src,
   output logic              err_overlong
);

   arb_state_t       state_reg, state_next;
   logic [IDX_W-1:0] grant_idx_reg, grant_idx_next;
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
   logic             pkt_done_reg, pkt_done_next;
   logic [IDX_W-1:0] pkt_src_reg, pkt_src_next;
   logic             err_overlong_reg, err_overlong_next;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic             hs;
   logic             at_limit;
   logic [IDX_W-1:0] ptr_after_grant;

   rr_pick #(
      .NUM_IN (NUM_IN),
      .IDX_W  (IDX_W)
   ) u_rr_pick (
      .req   (fifo_pkt_rdy),
      .ptr   (rr_ptr_reg),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign busy     = (state_reg == XFER);
   assign hs       = busy & mux_tvalid & axis_out_tready;
   assign at_limit = (beat_cnt_reg == CNT_W'(MAX_PKT_BEATS - 1));
   assign ptr_after_grant = (grant_idx_reg == IDX_W'(NUM_IN - 1)) ? '0
                                                                  : grant_idx_reg + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         grant_idx_reg    <= '0;
         rr_ptr_reg       <= '0;
         beat_cnt_reg     <= '0;
         pkt_done_reg     <= 1'b0;
         pkt_src_reg      <= '0;
         err_overlong_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         grant_idx_reg    <= grant_idx_next;
         rr_ptr_reg       <= rr_ptr_next;
         beat_cnt_reg     <= beat_cnt_next;
         pkt_done_reg     <= pkt_done_next;
         pkt_src_reg      <= pkt_src_next;
         err_overlong_reg <= err_overlong_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      grant_idx_next    = grant_idx_reg;
      rr_ptr_next       = rr_ptr_reg;
      beat_cnt_next     = beat_cnt_reg;
      pkt_done_next     = 1'b0;
      pkt_src_next      = pkt_src_reg;
      err_overlong_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (arb_en && pick_found) begin
               grant_idx_next = pick_idx;
               beat_cnt_next  = '0;
               state_next     = XFER;
            end
         end
         XFER: begin
            // Only handshaked beats advance the watchdog; stalls can last forever.
            if (hs) begin
               beat_cnt_next = beat_cnt_reg + CNT_W'(1);
               if (mux_tlast || at_limit) begin
                  state_next        = IDLE;
                  pkt_done_next     = 1'b1;
                  pkt_src_next      = grant_idx_reg;
                  rr_ptr_next       = ptr_after_grant;
                  err_overlong_next = ~mux_tlast;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus_sel      = busy ? sel_code(7'(grant_idx_reg)) : SEL_NONE;
   assign pkt_done     = pkt_done_reg;
   assign pkt_src      = pkt_src_reg;
   assign err_overlong = err_overlong_reg;

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_tready
         assign fifo_tready[gi] = busy & (grant_idx_reg == IDX_W'(gi)) & axis_out_tready;
      end
   endgenerate

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: drives packets as the bus mux would and
// scores completions against an expected-packet queue.
module tb_axis_pkt_arbiter;

   localparam int NUM_IN = 12;
   localparam int IDX_W  = 4;
   localparam int MAXB   = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              arb_en;
   logic [NUM_IN-1:0] fifo_pkt_rdy;
   logic              mux_tvalid;
   logic              mux_tlast;
   logic              axis_out_tready;
   logic [7:0]        bus_sel;
   logic [NUM_IN-1:0] fifo_tready;
   logic              busy;
   logic              pkt_done;
   logic [IDX_W-1:0]  pkt_src;
   logic              err_overlong;

   typedef struct packed {
      logic [IDX_W-1:0] src;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   axis_pkt_arbiter #(
      .NUM_IN        (NUM_IN),
      .IDX_W         (IDX_W),
      .MAX_PKT_BEATS (MAXB),
      .CNT_W         (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .arb_en          (arb_en),
      .fifo_pkt_rdy    (fifo_pkt_rdy),
      .mux_tvalid      (mux_tvalid),
      .mux_tlast       (mux_tlast),
      .axis_out_tready (axis_out_tready),
      .bus_sel         (bus_sel),
      .fifo_tready     (fifo_tready),
      .busy            (busy),
      .pkt_done        (pkt_done),
      .pkt_src         (pkt_src),
      .err_overlong    (err_overlong)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard side: every pkt_done pulse must match the oldest expected packet.
   always @(negedge clk) begin
      #2;
      if (pkt_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("sb_unexpected_done", 32'(pkt_done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            $display("pkt done: src=%0d overlong=%0d (expected src=%0d overlong=%0d)",
                     pkt_src, err_overlong, mon_e.src, mon_e.err);
            check_val("sb_src", 32'(pkt_src), 32'(mon_e.src));
            check_val("sb_err", 32'(err_overlong), 32'(mon_e.err));
         end
      end
   end

   task automatic push_exp(input int src, input bit err);
      exp_t e;
      e.src = IDX_W'(src);
      e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input int src, input bit chk_imm);
      int w = 0;
      @(negedge clk);
      #1;
      while (bus_sel == 8'd0 && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      check_val("grant_sel", 32'(bus_sel), 32'(128 + src));
      check_val("grant_busy", 32'(busy), 32'd1);
      check_val("done_is_pulse", 32'(pkt_done), 32'd0);
      if (chk_imm) check_val("grant_wait", 32'(w), 32'd0);
   endtask

   // Drives beats until exp_hs handshakes have occurred; optionally changes arb_en and
   // fifo_pkt_rdy while the handshake count equals mid_at.
   task automatic drive_beats(input int src, input int nbeats, input bit tlast_en,
                              input bit toggle, input int exp_hs, input int mid_at,
                              input bit mid_en, input logic [NUM_IN-1:0] mid_rdy);
      int                hs = 0;
      int                cyc = 0;
      logic              rdy_t;
      logic [NUM_IN-1:0] exp_tr;
      while (hs < exp_hs && cyc < 100) begin
         if (cyc > 0) @(negedge clk);
         rdy_t = toggle ? (cyc % 2 == 0) : 1'b1;
         if (hs == mid_at) begin
            arb_en       = mid_en;
            fifo_pkt_rdy = mid_rdy;
         end
         mux_tvalid      = 1'b1;
         axis_out_tready = rdy_t;
         mux_tlast       = tlast_en && (hs == nbeats - 1);
         #1;
         exp_tr = rdy_t ? (NUM_IN'(1) << src) : '0;
         check_val("fifo_tready", 32'(fifo_tready), 32'(exp_tr));
         if (rdy_t) hs++;
         cyc++;
      end
      check_val("beat_count", 32'(hs), 32'(exp_hs));
   endtask

   task automatic check_release(input int src, input bit err);
      @(negedge clk);
      mux_tvalid      = 1'b0;
      mux_tlast       = 1'b0;
      axis_out_tready = 1'b1;
      #1;
      check_val("rel_sel", 32'(bus_sel), 32'd0);
      check_val("rel_busy", 32'(busy), 32'd0);
      check_val("rel_done", 32'(pkt_done), 32'd1);
      check_val("rel_src", 32'(pkt_src), 32'(src));
      check_val("rel_err", 32'(err_overlong), 32'(err));
   endtask

   task automatic run_pkt(input int src, input int nbeats, input bit tlast_en, input bit toggle,
                          input int exp_hs, input bit exp_err, input bit chk_imm,
                          input int mid_at, input bit mid_en, input logic [NUM_IN-1:0] mid_rdy);
      wait_grant(src, chk_imm);
      push_exp(src, exp_err);
      drive_beats(src, nbeats, tlast_en, toggle, exp_hs, mid_at, mid_en, mid_rdy);
      check_release(src, exp_err);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst             = 1'b1;
      arb_en          = 1'b1;
      fifo_pkt_rdy    = 12'h010;
      mux_tvalid      = 1'b0;
      mux_tlast       = 1'b0;
      axis_out_tready = 1'b1;

      // Reset state with a request already pending
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_bus_sel", 32'(bus_sel), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_tready", 32'(fifo_tready), 32'd0);
      check_val("rst_done", 32'(pkt_done), 32'd0);
      check_val("rst_src", 32'(pkt_src), 32'd0);
      check_val("rst_err", 32'(err_overlong), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_pkt(4, 2, 1'b1, 1'b1, 2, 1'b0, 1'b1, -1, 1'b1, 12'h010);

      // Full round robin over all inputs, wrapping back to 0
      fifo_pkt_rdy = 12'hFFF;
      do_reset();
      for (int s = 0; s < 13; s++) begin
         run_pkt(s % NUM_IN, 3, 1'b1, 1'b0, 3, 1'b0, 1'b1, -1, 1'b1, 12'hFFF);
      end

      // Stalled packet from FIFO 7; its ready flag drops mid-packet
      fifo_pkt_rdy = 12'h080;
      run_pkt(7, 5, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1, 1'b1, 12'h000);

      // Watchdog release, then a back-to-back regrant of the single requester
      fifo_pkt_rdy = 12'h004;
      run_pkt(2, 10, 1'b0, 1'b0, MAXB, 1'b1, 1'b1, -1, 1'b1, 12'h004);
      run_pkt(2, 2, 1'b1, 1'b0, 2, 1'b0, 1'b1, -1, 1'b1, 12'h004);

      // arb_en drops during the 2nd beat: packet completes, then no grants
      fifo_pkt_rdy = 12'h008;
      run_pkt(3, 4, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1, 1'b0, 12'h0FF);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         check_val("disabled_sel", 32'(bus_sel), 32'd0);
         check_val("disabled_busy", 32'(busy), 32'd0);
      end
      arb_en = 1'b1;
      run_pkt(4, 1, 1'b1, 1'b0, 1, 1'b0, 1'b1, -1, 1'b1, 12'h0FF);

      // Reset on the 3rd beat of a packet from FIFO 9 abandons it
      fifo_pkt_rdy = 12'h200;
      wait_grant(9, 1'b1);
      drive_beats(9, 3, 1'b0, 1'b0, 2, -1, 1'b1, 12'h200);
      @(negedge clk);
      mux_tvalid      = 1'b1;
      axis_out_tready = 1'b1;
      rst             = 1'b1;
      #1;
      check_val("abort_tready_before", 32'(fifo_tready), 32'(12'h200));
      @(negedge clk);
      #1;
      check_val("abort_sel", 32'(bus_sel), 32'd0);
      check_val("abort_tready", 32'(fifo_tready), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_done", 32'(pkt_done), 32'd0);
      mux_tvalid   = 1'b0;
      fifo_pkt_rdy = 12'h201;
      @(negedge clk);
      rst = 1'b0;
      run_pkt(0, 1, 1'b1, 1'b0, 1, 1'b0, 1'b1, -1, 1'b1, 12'h201);

      repeat (2) @(negedge clk);
      #3;
      check_val("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
